// File: rtl/fcs_pkg.sv
// fcs_pkg: shared definitions for the serial Ethernet FCS generator and checker.
//   CRC_POLY / CRC_INIT : default CRC-32 polynomial and start-of-frame register value
//   fcs_gen_state_t     : generator FSM states
//   crc32_step()        : one MSB-first CRC-32 step for a single input bit
package fcs_pkg;

    localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PAYLOAD = 2'd1,
        FCS     = 2'd2
    } fcs_gen_state_t;

    function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic d,
                                               input logic [31:0] poly = CRC_POLY);
        logic fb;
        fb = crc[31] ^ d;
        return {crc[30:0], 1'b0} ^ (fb ? poly : 32'h0);
    endfunction

endpackage

// File: rtl/fcs_crc_serial.sv
// fcs_crc_serial: bit-serial CRC-32 register with init/step/hold control.
//   clk, reset   : clock, asynchronous active-high reset (register clears to 0)
//   init_i       : load INIT and step it with data_i (first bit of a frame)
//   step_i       : step the running CRC with data_i
//   data_i       : payload bit, MSB first
//   crc_next_o   : value the register takes at the next edge (includes data_i)
module fcs_crc_serial
    import fcs_pkg::*;
#(
    parameter logic [31:0] POLY = CRC_POLY,
    parameter logic [31:0] INIT = CRC_INIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        init_i,
    input  logic        step_i,
    input  logic        data_i,
    output logic [31:0] crc_next_o
);

    logic [31:0] crc_q, crc_d;

    // init wins over step so a restart mid-frame discards the old remainder
    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = crc32_step(INIT, data_i, POLY);
        end else if (step_i) begin
            crc_d = crc32_step(crc_q, data_i, POLY);
        end
    end

    assign crc_next_o = crc_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= '0;
        end else begin
            crc_q <= crc_d;
        end
    end

endmodule

// File: rtl/fcs_serial_gen.sv
// fcs_serial_gen: serial Ethernet FCS generator. Forwards a MSB-first payload with one
// cycle of latency and appends the complemented CRC-32 right after the last payload bit.
//   clk, reset       : clock, asynchronous active-high reset
//   start_of_frame   : marks the first payload bit on data_in
//   end_of_frame     : marks the last payload bit on data_in
//   data_in          : payload bit
//   fcs_corrupt      : (FCS_GEN_ERR_INJECT_EN only) invert FCS bits 31:30, sampled with EOF
//   ready            : input accepted; low while the FCS is shifted out
//   data_out         : registered payload or FCS bit
//   out_valid        : data_out carries a frame bit
//   out_sof          : data_out is the first payload bit
//   fcs_start        : data_out is FCS bit 31
//   out_eof          : data_out is FCS bit 0
// Build option: define FCS_GEN_ERR_INJECT_EN to add the fcs_corrupt error-injection port.
module fcs_serial_gen
    import fcs_pkg::*;
#(
    parameter logic [31:0] POLY = CRC_POLY,
    parameter logic [31:0] INIT = CRC_INIT
) (
    input  logic clk,
    input  logic reset,
    input  logic start_of_frame,
    input  logic end_of_frame,
    input  logic data_in,
`ifdef FCS_GEN_ERR_INJECT_EN
    input  logic fcs_corrupt,
`endif
    output logic ready,
    output logic data_out,
    output logic out_valid,
    output logic out_sof,
    output logic fcs_start,
    output logic out_eof
);

    fcs_gen_state_t state_q, state_d;
    logic [31:0]    fcs_sr_q, fcs_sr_d;
    logic [4:0]     cnt_q, cnt_d;
    logic           data_q, data_d;
    logic           valid_q, valid_d;
    logic           sof_q, sof_d;
    logic           fstart_q, fstart_d;
    logic           eof_q, eof_d;

    logic           accept_sof;
    logic           in_payload;
    logic           take_bit;
    logic [31:0]    crc_next;
    logic [31:0]    fcs_mask;

    assign ready      = (state_q != FCS);
    assign accept_sof = ready & start_of_frame;
    assign in_payload = (state_q == PAYLOAD);
    assign take_bit   = accept_sof | in_payload;

`ifdef FCS_GEN_ERR_INJECT_EN
    assign fcs_mask = fcs_corrupt ? 32'hC000_0000 : 32'h0;
`else
    assign fcs_mask = 32'h0;
`endif

    fcs_crc_serial #(
        .POLY (POLY),
        .INIT (INIT)
    ) u_crc (
        .clk        (clk),
        .reset      (reset),
        .init_i     (accept_sof),
        .step_i     (in_payload),
        .data_i     (data_in),
        .crc_next_o (crc_next)
    );

    always_comb begin
        state_d  = state_q;
        fcs_sr_d = fcs_sr_q;
        cnt_d    = cnt_q;
        data_d   = 1'b0;
        valid_d  = 1'b0;
        sof_d    = 1'b0;
        fstart_d = 1'b0;
        eof_d    = 1'b0;

        case (state_q)
            FCS: begin
                data_d   = fcs_sr_q[31];
                valid_d  = 1'b1;
                fstart_d = (cnt_q == 5'd31);
                eof_d    = (cnt_q == 5'd0);
                fcs_sr_d = {fcs_sr_q[30:0], 1'b0};
                cnt_d    = cnt_q - 5'd1;
                if (cnt_q == 5'd0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                // IDLE and PAYLOAD: a SOF here also aborts any frame in progress
                if (take_bit) begin
                    data_d  = data_in;
                    valid_d = 1'b1;
                    sof_d   = accept_sof;
                    state_d = PAYLOAD;
                    if (end_of_frame) begin
                        fcs_sr_d = ~crc_next ^ fcs_mask;
                        cnt_d    = 5'd31;
                        state_d  = FCS;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            fcs_sr_q <= '0;
            cnt_q    <= '0;
            data_q   <= 1'b0;
            valid_q  <= 1'b0;
            sof_q    <= 1'b0;
            fstart_q <= 1'b0;
            eof_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            fcs_sr_q <= fcs_sr_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            sof_q    <= sof_d;
            fstart_q <= fstart_d;
            eof_q    <= eof_d;
        end
    end

    assign data_out  = data_q;
    assign out_valid = valid_q;
    assign out_sof   = sof_q;
    assign fcs_start = fstart_q;
    assign out_eof   = eof_q;

endmodule

// File: tb/tb_fcs_serial_gen.sv
// tb_fcs_serial_gen: directed bench for fcs_serial_gen. Expected FCS values are literal
// hand values (one-bit payloads, CRC-32/BZIP2 check of "123456789") or come from
// calc_crc, an augmented long-division model independent of the shift-register form.
module tb_fcs_serial_gen;

    localparam logic [31:0] POLY = 32'h04C1_1DB7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start_of_frame = 1'b0;
    logic end_of_frame = 1'b0;
    logic data_in = 1'b0;
`ifdef FCS_GEN_ERR_INJECT_EN
    logic fcs_corrupt = 1'b0;
`endif
    logic ready, data_out, out_valid, out_sof, fcs_start, out_eof;

    fcs_serial_gen dut (
        .clk            (clk),
        .reset          (reset),
        .start_of_frame (start_of_frame),
        .end_of_frame   (end_of_frame),
        .data_in        (data_in),
`ifdef FCS_GEN_ERR_INJECT_EN
        .fcs_corrupt    (fcs_corrupt),
`endif
        .ready          (ready),
        .data_out       (data_out),
        .out_valid      (out_valid),
        .out_sof        (out_sof),
        .fcs_start      (fcs_start),
        .out_eof        (out_eof)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic pay [0:1023];
    logic ov_data [0:2047];
    logic ov_sof  [0:2047];
    logic ov_fst  [0:2047];
    logic ov_eof  [0:2047];
    int   ov_cyc  [0:2047];
    int   ocnt    = 0;
    int   cyc     = 0;
    int   rdy_low = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Augmented division: message * x^32 with the first 32 bits complemented (INIT = ones).
    function automatic logic [31:0] calc_crc(input int n);
        logic [31:0] r;
        logic        b, msb;
        r = 32'h0;
        for (int i = 0; i < n + 32; i++) begin
            b = (i < n) ? pay[i] : 1'b0;
            if (i < 32) b = ~b;
            msb = r[31];
            r = {r[30:0], b};
            if (msb) r = r ^ POLY;
        end
        return ~r;
    endfunction

    task automatic clear_rec();
        ocnt    = 0;
        rdy_low = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (!ready) rdy_low++;
        if (out_valid) begin
            ov_data[ocnt] = data_out;
            ov_sof[ocnt]  = out_sof;
            ov_fst[ocnt]  = fcs_start;
            ov_eof[ocnt]  = out_eof;
            ov_cyc[ocnt]  = cyc;
            if (ocnt < 2047) ocnt++;
        end
    endtask

    // which: 0 = out_sof, 1 = fcs_start, 2 = out_eof
    function automatic int find_flag(input int which, input int from);
        for (int i = from; i < ocnt; i++) begin
            if ((which == 0 && ov_sof[i]) || (which == 1 && ov_fst[i]) ||
                (which == 2 && ov_eof[i])) return i;
        end
        return -1;
    endfunction

    function automatic int count_flag(input int which);
        int c;
        c = 0;
        for (int i = 0; i < ocnt; i++) begin
            if ((which == 0 && ov_sof[i]) || (which == 1 && ov_fst[i]) ||
                (which == 2 && ov_eof[i])) c++;
        end
        return c;
    endfunction

    function automatic logic [31:0] fcs_at(input int k);
        logic [31:0] f;
        f = 32'h0;
        if (k < 0 || k + 32 > ocnt) return 32'hDEAD_0000;
        for (int i = 0; i < 32; i++) f = {f[30:0], ov_data[k + i]};
        return f;
    endfunction

    task automatic drive_payload(input int n, input bit with_eof, input bit corrupt);
        for (int i = 0; i < n; i++) begin
            start_of_frame = (i == 0);
            end_of_frame   = with_eof && (i == n - 1);
            data_in        = pay[i];
`ifdef FCS_GEN_ERR_INJECT_EN
            fcs_corrupt    = corrupt && end_of_frame;
`endif
            tick();
        end
        start_of_frame = 1'b0;
        end_of_frame   = 1'b0;
        data_in        = 1'b0;
`ifdef FCS_GEN_ERR_INJECT_EN
        fcs_corrupt    = 1'b0;
`endif
    endtask

    task automatic send_frame(input int n, input bit junk, input bit corrupt);
        drive_payload(n, 1'b1, corrupt);
        for (int i = 0; i < 32; i++) begin
            if (junk) begin
                start_of_frame = 1'b1;
                end_of_frame   = 1'($urandom_range(0, 1));
                data_in        = 1'($urandom_range(0, 1));
            end
            tick();
        end
        start_of_frame = 1'b0;
        end_of_frame   = 1'b0;
        data_in        = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int n, input logic [31:0] exp);
        int k;
        k = find_flag(1, 0);
        check({tag, " fcs"}, fcs_at(k), exp);
        check({tag, " fcs_start idx"}, k, n);
        check({tag, " out_eof idx"}, find_flag(2, 0), n + 31);
        check({tag, " valid bits"}, ocnt, n + 32);
        check({tag, " sof count"}, count_flag(0), 1);
        check({tag, " sof idx"}, find_flag(0, 0), 0);
    endtask

    task automatic load_123456789();
        logic [7:0] byte_v;
        for (int b = 0; b < 9; b++) begin
            byte_v = 8'h31 + 8'(b);
            for (int j = 0; j < 8; j++) pay[b * 8 + j] = byte_v[7 - j];
        end
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) pay[i] = 1'($urandom_range(0, 1));
    endtask

    initial begin
        logic [31:0] exp_a, exp_b;
        int k;

        // Reset state while reset is held
        #12;
        check("reset outputs", {26'h0, ready, data_out, out_valid, out_sof, fcs_start, out_eof},
              32'h20);
        #5 reset = 1'b0;

        // Bits in IDLE without SOF are dropped
        clear_rec();
        data_in = 1'b1;
        end_of_frame = 1'b1;
        repeat (5) tick();
        data_in = 1'b0;
        end_of_frame = 1'b0;
        check("idle no valid", ocnt, 0);

        // One-bit payloads: SOF and EOF together
        clear_rec();
        pay[0] = 1'b1;
        send_frame(1, 1'b0, 1'b0);
        check_frame("1bit d1", 1, 32'h0000_0001);
        check("1bit d1 model", fcs_at(1), calc_crc(1));
        check("1bit ready low cycles", rdy_low, 32);

        clear_rec();
        pay[0] = 1'b0;
        send_frame(1, 1'b0, 1'b0);
        check_frame("1bit d0", 1, 32'h04C1_1DB6);

        // "123456789" -> CRC-32/BZIP2 check value
        clear_rec();
        load_123456789();
        send_frame(72, 1'b0, 1'b0);
        check_frame("ascii", 72, 32'hFC89_1918);
        check("ascii model", calc_crc(72), 32'hFC89_1918);

        // Random 512-bit payload; FCS bit 31 is output bit 513, bit 0 is 544
        clear_rec();
        load_random(512);
        exp_a = calc_crc(512);
        send_frame(512, 1'b0, 1'b0);
        check_frame("rand512", 512, exp_a);
        check("rand512 payload bit 100", ov_data[100], pay[100]);

        // SOF / EOF / junk data during the FCS phase are ignored
        clear_rec();
        load_123456789();
        send_frame(72, 1'b1, 1'b0);
        tick();
        check_frame("junk", 72, 32'hFC89_1918);
        check("junk no eof count", count_flag(2), 1);

        // Back-to-back frames with SOF at the first allowed edge
        clear_rec();
        load_random(40);
        exp_a = calc_crc(40);
        send_frame(40, 1'b0, 1'b0);
        load_random(24);
        exp_b = calc_crc(24);
        send_frame(24, 1'b0, 1'b0);
        tick();
        check("b2b valid bits", ocnt, 40 + 32 + 24 + 32);
        check("b2b contiguous", ov_cyc[ocnt - 1] - ov_cyc[0], ocnt - 1);
        check("b2b fcs A", fcs_at(find_flag(1, 0)), exp_a);
        check("b2b second sof idx", find_flag(0, 1), 72);
        k = find_flag(1, 73);
        check("b2b fcs_start B idx", k, 72 + 24);
        check("b2b fcs B", fcs_at(k), exp_b);

        // SOF during PAYLOAD aborts the frame without an FCS
        clear_rec();
        load_random(20);
        drive_payload(20, 1'b0, 1'b0);
        load_random(16);
        exp_b = calc_crc(16);
        send_frame(16, 1'b0, 1'b0);
        check("abort sof count", count_flag(0), 2);
        check("abort fcs_start count", count_flag(1), 1);
        check("abort fcs_start idx", find_flag(1, 0), 36);
        check("abort fcs", fcs_at(36), exp_b);
        check("abort valid bits", ocnt, 20 + 16 + 32);

        // Asynchronous reset during the FCS phase
        clear_rec();
        load_random(30);
        drive_payload(30, 1'b1, 1'b0);
        repeat (10) tick();
        #2 reset = 1'b1;
        #1;
        check("mid-fcs reset outputs",
              {26'h0, ready, data_out, out_valid, out_sof, fcs_start, out_eof}, 32'h20);
        #1 reset = 1'b0;
        clear_rec();
        load_random(48);
        exp_a = calc_crc(48);
        send_frame(48, 1'b0, 1'b0);
        check_frame("after reset", 48, exp_a);

`ifdef FCS_GEN_ERR_INJECT_EN
        // Error injection flips FCS bits 31:30
        clear_rec();
        load_123456789();
        send_frame(72, 1'b0, 1'b1);
        check_frame("corrupt", 72, 32'h3C89_1918);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
